// File: rtl/piano_key_ctrl_pkg.sv
// piano_pkg: shared types and constants for the piano key controller.
//   NKEYS        number of keys (key i -> note code i)
//   note_t       4-bit note code
//   state_t      controller FSM states
//   HALF_PERIOD  tone half-periods in 50 MHz cycles, C4..E5
package piano_pkg;

    localparam int NKEYS  = 10;
    localparam int TONE_W = 17;

    typedef logic [3:0] note_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } state_t;

    localparam logic [TONE_W-1:0] HALF_PERIOD [0:NKEYS-1] = '{
        17'd95556, 17'd85131, 17'd75843, 17'd71586, 17'd63776,
        17'd56818, 17'd50619, 17'd47778, 17'd42566, 17'd37921
    };

    // Lowest-index set bit wins; scanning downward leaves the lowest one.
    function automatic note_t lowest_key(input logic [NKEYS-1:0] keys);
        note_t n;
        n = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (keys[i]) n = note_t'(i);
        end
        return n;
    endfunction

    // Scaled half-period, clamped to 1 so a fully shifted-out entry
    // still toggles every cycle instead of stalling the divider.
    function automatic logic [TONE_W-1:0] half_period(input note_t c,
                                                      input int unsigned shift);
        logic [TONE_W-1:0] hp;
        hp = HALF_PERIOD[c] >> shift;
        if (hp == '0) hp = TONE_W'(1);
        return hp;
    endfunction

endpackage

// File: rtl/piano_key_ctrl_if.sv
// piano_key_ctrl_if: key inputs and note outputs of the controller.
//   key_in      raw key switches (bit i = key i)
//   note_code   active note code, 0 when silent
//   note_valid  high while a note plays
//   note_start  one-cycle pulse on the first cycle of a note
//   tone_out    square wave at the active note's pitch
// master: key/switch side (drives key_in); slave: controller.
interface piano_key_ctrl_if;
    import piano_pkg::*;

    logic [NKEYS-1:0] key_in;
    note_t            note_code;
    logic             note_valid;
    logic             note_start;
    logic             tone_out;

    modport master (
        output key_in,
        input  note_code, note_valid, note_start, tone_out
    );

    modport slave (
        input  key_in,
        output note_code, note_valid, note_start, tone_out
    );

endinterface

// File: rtl/piano_key_ctrl_debounce.sv
// key_debounce: 2-flop synchroniser plus debounce counter for one key.
//   clk, rst_n  clock, async active-low reset
//   i_key       raw asynchronous key switch
//   o_db        debounced key level
// o_db follows the synchronised input only after it has differed from
// o_db for DEB_CYCLES consecutive cycles; any bounce restarts the count.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_db
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_key};
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                // This is the DEB_CYCLES-th consecutive differing cycle.
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/piano_key_ctrl.sv
// piano_key_ctrl: debounces ten keys, arbitrates one active note
// (lowest index, no preemption) and generates its square-wave tone.
//   clk, rst_n  clock, async active-low reset
//   bus         piano_key_ctrl_if.slave (key_in in; note_* / tone_out out)
// Sequencing: IDLE -> PLAY on any debounced key, PLAY -> GAP when the
// active key releases, GAP -> IDLE after GAP_CYCLES silent cycles.
module piano_key_ctrl
    import piano_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned HP_SHIFT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    piano_key_ctrl_if.slave  bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [NKEYS-1:0] w_key_db;

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .i_key (bus.key_in[g]),
            .o_db  (w_key_db[g])
        );
    end

    state_t            r_state,    w_state_nxt;
    note_t             r_cur,      w_cur_nxt;
    note_t             r_code,     w_code_nxt;
    logic [TONE_W-1:0] r_tone_cnt, w_tone_cnt_nxt;
    logic [GW-1:0]     r_gap_cnt,  w_gap_cnt_nxt;
    logic              r_tone,     w_tone_nxt;
    logic              r_valid,    w_valid_nxt;
    logic              r_start,    w_start_nxt;
    note_t             w_pick;

    assign w_pick = lowest_key(w_key_db);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cur      <= '0;
            r_code     <= '0;
            r_tone_cnt <= '0;
            r_gap_cnt  <= '0;
            r_tone     <= 1'b0;
            r_valid    <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_code     <= w_code_nxt;
            r_tone_cnt <= w_tone_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_tone     <= w_tone_nxt;
            r_valid    <= w_valid_nxt;
            r_start    <= w_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_nxt      = r_cur;
        w_code_nxt     = r_code;
        w_tone_cnt_nxt = r_tone_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_tone_nxt     = r_tone;
        w_valid_nxt    = r_valid;
        w_start_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_key_db) begin
                    w_state_nxt    = ST_PLAY;
                    w_cur_nxt      = w_pick;
                    w_code_nxt     = w_pick;
                    w_start_nxt    = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_tone_nxt     = 1'b0;
                    w_tone_cnt_nxt = half_period(w_pick, HP_SHIFT);
                end
            end
            ST_PLAY: begin
                // Only the active key is watched: other presses are ignored,
                // so a release coinciding with a new press still ends here.
                if (!w_key_db[r_cur]) begin
                    w_state_nxt   = ST_GAP;
                    w_valid_nxt   = 1'b0;
                    w_tone_nxt    = 1'b0;
                    w_code_nxt    = '0;
                    w_gap_cnt_nxt = '0;
                end else if (r_tone_cnt == TONE_W'(1)) begin
                    w_tone_nxt     = ~r_tone;
                    w_tone_cnt_nxt = half_period(r_cur, HP_SHIFT);
                end else begin
                    w_tone_cnt_nxt = r_tone_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.note_code  = r_code;
    assign bus.note_valid = r_valid;
    assign bus.note_start = r_start;
    assign bus.tone_out   = r_tone;

endmodule

// File: tb/tb_piano_key_ctrl.sv
// Bench for piano_key_ctrl: dut_a (HP_SHIFT=12) is watched by a scoreboard
// monitor; dut_b (HP_SHIFT=20) covers the clamped half-period of 1.
module tb_piano_key_ctrl;
    import piano_pkg::*;

    localparam int DEB = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piano_key_ctrl_if bus_a ();
    piano_key_ctrl_if bus_b ();

    piano_key_ctrl #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAP), .HP_SHIFT(12)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    piano_key_ctrl #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAP), .HP_SHIFT(20)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int HPT[10] = '{95556, 85131, 75843, 71586, 63776,
                    56818, 50619, 47778, 42566, 37921};

    function automatic int hp_a(input int c);
        int h;
        h = HPT[c] >>> 12;
        if (h < 1) h = 1;
        return h;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor on dut_a ----------------
    int   exp_code   = 0;
    int   last_tgl   = 0;
    int   fall_cyc   = -100;
    logic prev_tone  = 1'b0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (bus_a.note_start) begin
            if (sb.size() == 0) begin
                chk("spurious_start", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("start_code", int'(bus_a.note_code), mon_e.code);
                chk("start_cycle", cyc, mon_e.cyc);
                exp_code = mon_e.code;
            end
            chk("start_valid", int'(bus_a.note_valid), 1);
            chk("start_tone_low", int'(bus_a.tone_out), 0);
            chk("gap_respected", int'((cyc - fall_cyc) >= GAP + 1), 1);
            last_tgl = cyc;
        end else if (bus_a.note_valid) begin
            chk("hold_code", int'(bus_a.note_code), exp_code);
            if (bus_a.tone_out != prev_tone) begin
                chk("half_period", cyc - last_tgl, hp_a(exp_code));
                last_tgl = cyc;
            end
        end else begin
            chk("idle_quiet", int'({bus_a.tone_out, bus_a.note_code}), 0);
        end
        if (prev_valid && !bus_a.note_valid) fall_cyc = cyc;
        prev_valid = bus_a.note_valid;
        prev_tone  = bus_a.tone_out;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive keys (at a negedge) and expect a note_start lat cycles later.
    task automatic press(input logic [9:0] k, input int code, input int lat);
        exp_t e;
        bus_a.key_in = k;
        e.code = code;
        e.cyc  = cyc + lat;
        sb.push_back(e);
    endtask

    initial begin : main
        int   k;
        logic pt;
        bus_a.key_in = '0;
        bus_b.key_in = '0;
        rst_n = 1'b0;
        tick(3);
        chk("rst_code", int'(bus_a.note_code), 0);
        chk("rst_valid", int'(bus_a.note_valid), 0);
        chk("rst_start", int'(bus_a.note_start), 0);
        chk("rst_tone", int'(bus_a.tone_out), 0);
        chk("rst_b_valid", int'(bus_b.note_valid), 0);
        rst_n = 1'b1;
        tick(5);
        chk("idle_valid", int'(bus_a.note_valid), 0);

        // Single key 4: press/release latency edges.
        press(10'h010, 4, 3 + DEB);
        tick(2 + DEB);
        chk("press_lat_early", int'(bus_a.note_valid), 0);
        tick(1);
        chk("press_lat", int'(bus_a.note_valid), 1);
        tick(60);
        bus_a.key_in = '0;
        tick(2 + DEB);
        chk("rel_lat_early", int'(bus_a.note_valid), 1);
        tick(1);
        chk("rel_lat", int'(bus_a.note_valid), 0);
        tick(12);

        // Key 7 bounce: 2-cycle pulses never pass the debouncer.
        for (int i = 0; i < 2; i++) begin
            bus_a.key_in = 10'h080; tick(2);
            bus_a.key_in = 10'h000; tick(2);
        end
        press(10'h080, 7, 3 + DEB);
        tick(30);
        bus_a.key_in = '0;
        tick(15);

        // Keys 2,5,7 together, released in turn.
        press(10'h0A4, 2, 3 + DEB);
        tick(30);
        press(10'h0A0, 5, 3 + DEB + GAP + 1);
        tick(30);
        press(10'h080, 7, 3 + DEB + GAP + 1);
        tick(30);
        bus_a.key_in = '0;
        tick(15);

        // Key 3 playing, key 1 pressed: no preemption.
        press(10'h008, 3, 3 + DEB);
        tick(20);
        bus_a.key_in = 10'h00A;
        tick(30);
        chk("no_preempt", int'(bus_a.note_code), 3);
        press(10'h002, 1, 3 + DEB + GAP + 1);
        tick(30);
        bus_a.key_in = '0;
        tick(15);

        // Async reset mid-note while tone is high.
        press(10'h010, 4, 3 + DEB);
        k = 0;
        while (bus_a.tone_out !== 1'b1 && k < 60) begin
            tick(1);
            k++;
        end
        chk("tone_high_seen", int'(bus_a.tone_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tone", int'(bus_a.tone_out), 0);
        chk("async_valid", int'(bus_a.note_valid), 0);
        chk("async_code", int'(bus_a.note_code), 0);
        @(negedge clk);
        rst_n = 1'b1;
        press(10'h010, 4, 3 + DEB);
        tick(3 + DEB);
        chk("retrigger_valid", int'(bus_a.note_valid), 1);
        tick(20);
        bus_a.key_in = '0;
        tick(15);

        // dut_b: half-period clamps to 1, tone toggles every cycle.
        bus_b.key_in = 10'h001;
        k = 0;
        while (!bus_b.note_start && k < 20) begin
            tick(1);
            k++;
        end
        chk("b_start_seen", int'(bus_b.note_start), 1);
        chk("b_start_lat", k, 3 + DEB);
        chk("b_start_tone", int'(bus_b.tone_out), 0);
        for (int i = 0; i < 6; i++) begin
            pt = bus_b.tone_out;
            tick(1);
            chk("b_toggle", int'(bus_b.tone_out), int'(!pt));
        end
        chk("b_code", int'(bus_b.note_code), 0);
        bus_b.key_in = '0;

        tick(5);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/piano_key_ctrl.md
# piano_key_ctrl

Controller for the ten piano keys. Synchronises and debounces the raw key inputs and arbitrates simultaneous presses into a single active note. It emits the note's 4-bit code, using the same key-to-code mapping as the piano's decimal-to-BCD encoder (key i → code i), and generates the square-wave tone for that note. It sits between the key switches and the speaker/encoder path, and sequences note start, sustain and release.

## Interface

- DEB_CYCLES, 4, consecutive stable cycles required before a debounced key changes state (≥1)
- GAP_CYCLES, 2, silent cycles forced after a note releases before the next note may start (≥1)
- HP_SHIFT, 0, right-shift applied to every half-period table entry (shortens tones for simulation)

- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- key_in  in  10  raw key switches, active-high, asynchronous to clk; bit i = key i
- note_code  out  4  code of the active note (0–9); 0 when no note is active
- note_valid  out  1  high while a note is playing
- note_start  out  1  one-cycle pulse on the first cycle of each note
- tone_out  out  1  square wave at the active note's pitch; 0 when idle or in gap

## Operation

- Input path: each key_in bit passes through a 2-flop synchroniser, then a per-key debounce counter.
  - key_db[i] changes only after the synchronised value has differed from key_db[i] for DEB_CYCLES consecutive cycles.
  - Any bounce resets that key's counter to 0.
- FSM states are IDLE, PLAY and GAP.
- IDLE:
  - If any key_db bit is 1, latch the lowest-index set bit as cur and go to PLAY.
  - note_start=1 and note_valid=1 from that same edge.
- PLAY:
  - note_code=cur.
  - tone_out toggles every (HALF_PERIOD[cur] >> HP_SHIFT) cycles, starting from 0; minimum effective half-period is 1.
  - Presses of other keys are ignored; there is no preemption.
  - When key_db[cur] falls: go to GAP, and note_valid, tone_out and note_code are cleared on that edge.
- GAP:
  - Counts GAP_CYCLES cycles, then returns to IDLE.
  - A key still held re-triggers from IDLE using lowest-index arbitration.
- Tone counter width is 17 bits. The counter reloads on every toggle and on entry to PLAY.
- Reset: all state clears asynchronously.
  - Outputs reset to note_code=0, note_valid=0, note_start=0, tone_out=0.
  - FSM goes to IDLE; synchronisers, key_db and all counters go to 0.
  - Reset during PLAY or GAP silences the tone immediately.

## Timing

- Press latency: raw key_in stable high at edge 0 → key_db high after edge 2+DEB_CYCLES → note_start/note_valid high after the next edge (3+DEB_CYCLES).
- Release latency: raw low at edge 0 → note_valid low after edge 3+DEB_CYCLES.
- Gap: after note_valid falls, at least GAP_CYCLES+1 cycles pass before the next note_start.
- First tone_out rise: HP cycles after note_start, where HP = HALF_PERIOD[cur] >> HP_SHIFT. Tone period is 2·HP thereafter.
- Simultaneous debounced presses on the same cycle: the lowest index wins.
- Release of cur together with a press of another key on the same cycle: release wins; the new key starts after the gap.
- A bounce shorter than DEB_CYCLES never reaches key_db and produces no output change.

## Structure

- Package piano_pkg holds:
  - NKEYS=10
  - the note code typedef (4 bits)
  - the FSM state enum
  - HALF_PERIOD[0:9] as 17-bit constants for a 50 MHz clock, C4..E5 scale: 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778, 42566, 37921
- Sub-module key_debounce (one instance per key: synchroniser plus counter) is generated 10×.
- Arbitration, FSM and the tone divider live in piano_key_ctrl.

## Test plan

- Reset then idle, with HP_SHIFT=12: all outputs 0. Hold key_in=10'h010 → note_start pulse at cycle 7 (DEB_CYCLES=4), note_code=4, tone_out toggling every 15 cycles.
- Key 7 bounces 1-0-1-0 with 2-cycle pulses, then holds steady → only one note_start, occurring 7 cycles after the last edge.
- key_in=10'h0A4 applied in one cycle → note_code=2. Release key 2 → after the gap note_code=5, then 7 as keys are released in turn.
- Key 3 playing, then key 1 pressed → note_code stays 3 until key 3 releases. After 3 silent cycles note_code=1 starts.
- rst_n driven low mid-PLAY with tone_out=1 → tone_out, note_valid and note_code go to 0 asynchronously. After release with key held → a new note_start 7 cycles later.
- HP_SHIFT=20 (table >> 20 = 0) → effective HP=1; tone_out toggles every cycle, with no lockup.
